// File: rtl/riscv_mem_if.sv
// rtl/riscv_mem_if.sv - EX->MEM, data bus and MEM->WB signal bundle for riscv_mem
`ifndef MEM_FUNCT_W
`define MEM_FUNCT_W 4
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LH  4'd2
`define MEM_LW  4'd3
`define MEM_LBU 4'd4
`define MEM_LHU 4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

interface riscv_mem_if;
    logic                    ds_rdy;
    logic                    ds_ack;
    logic [31:0]             ex_mem_result;
    logic [`MEM_FUNCT_W-1:0] ex_mem_funct;
    logic [31:0]             ex_mem_data;
    logic [4:0]              ex_mem_wb_rsd;
    logic                    dbus_req;
    logic                    dbus_we;
    logic [31:0]             dbus_addr;
    logic [3:0]              dbus_be;
    logic [31:0]             dbus_wdata;
    logic                    dbus_gnt;
    logic                    dbus_rvalid;
    logic [31:0]             dbus_rdata;
    logic                    us_rdy;
    logic                    us_ack;
    logic [31:0]             mem_wb_data;
    logic [4:0]              mem_wb_rsd;
    logic                    mem_wb_we;
    logic                    mem_wb_misalign;

    modport slave (
        input  ds_rdy, ex_mem_result, ex_mem_funct, ex_mem_data, ex_mem_wb_rsd,
        input  dbus_gnt, dbus_rvalid, dbus_rdata, us_ack,
        output ds_ack, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output us_rdy, mem_wb_data, mem_wb_rsd, mem_wb_we, mem_wb_misalign
    );

    modport master (
        output ds_rdy, ex_mem_result, ex_mem_funct, ex_mem_data, ex_mem_wb_rsd,
        output dbus_gnt, dbus_rvalid, dbus_rdata, us_ack,
        input  ds_ack, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  us_rdy, mem_wb_data, mem_wb_rsd, mem_wb_we, mem_wb_misalign
    );
endinterface

// File: rtl/riscv_mem.sv
// rtl/riscv_mem.sv - pipeline memory stage: EX payload in, data-bus access, WB payload out
`ifndef MEM_FUNCT_W
`define MEM_FUNCT_W 4
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LH  4'd2
`define MEM_LW  4'd3
`define MEM_LBU 4'd4
`define MEM_LHU 4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module riscv_mem #(
    parameter int ALIGN_CHECK = 1
) (
    input  logic         clk,
    input  logic         rstn,
    riscv_mem_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    state_t                  state;
    logic                    us_rdy_q;
    logic                    dbus_req_q;
    logic                    dbus_we_q;
    logic [31:0]             dbus_addr_q;
    logic [3:0]              dbus_be_q;
    logic [31:0]             dbus_wdata_q;
    logic [31:0]             wb_data_q;
    logic [4:0]              wb_rsd_q;
    logic                    wb_we_q;
    logic                    wb_misalign_q;
    logic [1:0]              a_q;
    logic [`MEM_FUNCT_W-1:0] funct_q;
    logic [4:0]              rsd_q;

    logic        is_load, is_store, is_half, is_word, misalign, accept, ds_ack;
    logic [1:0]  in_a, eff_a;
    logic [3:0]  be_in;
    logic [31:0] wdata_in, load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (bus.ex_mem_funct)
            `MEM_LB, `MEM_LBU: is_load = 1'b1;
            `MEM_LH, `MEM_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            `MEM_LW:           begin is_load = 1'b1; is_word = 1'b1; end
            `MEM_SB:           is_store = 1'b1;
            `MEM_SH:           begin is_store = 1'b1; is_half = 1'b1; end
            `MEM_SW:           begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    // Without alignment checking the low address bits below the access size are dropped.
    assign in_a     = bus.ex_mem_result[1:0];
    assign misalign = (is_half && in_a[0]) || (is_word && (in_a != 2'b00));
    assign eff_a    = is_word ? 2'b00 : (is_half ? {in_a[1], 1'b0} : in_a);
    assign be_in    = is_word ? 4'b1111 : (is_half ? (4'b0011 << eff_a) : (4'b0001 << eff_a));
    assign wdata_in = is_word ? bus.ex_mem_data :
                      (is_half ? {2{bus.ex_mem_data[15:0]}} : {4{bus.ex_mem_data[7:0]}});

    // Accepting while OUT lets a new payload replace the one being drained on the same edge.
    assign ds_ack = ((state == IDLE) || (state == OUT)) && (!us_rdy_q || bus.us_ack);
    assign accept = bus.ds_rdy && ds_ack;

    assign byte_sel = bus.dbus_rdata[{a_q, 3'b000} +: 8];
    assign half_sel = bus.dbus_rdata[{a_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = bus.dbus_rdata;
        case (funct_q)
            `MEM_LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
            `MEM_LBU: load_val = {24'h0, byte_sel};
            `MEM_LH:  load_val = {{16{half_sel[15]}}, half_sel};
            `MEM_LHU: load_val = {16'h0, half_sel};
            default:  load_val = bus.dbus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            us_rdy_q      <= 1'b0;
            dbus_req_q    <= 1'b0;
            dbus_we_q     <= 1'b0;
            dbus_addr_q   <= 32'h0;
            dbus_be_q     <= 4'h0;
            dbus_wdata_q  <= 32'h0;
            wb_data_q     <= 32'h0;
            wb_rsd_q      <= 5'h0;
            wb_we_q       <= 1'b0;
            wb_misalign_q <= 1'b0;
            a_q           <= 2'b00;
            funct_q       <= `MEM_NOP;
            rsd_q         <= 5'h0;
        end else begin
            case (state)
                IDLE, OUT: begin
                    if (accept) begin
                        if ((is_load || is_store) && misalign && (ALIGN_CHECK != 0)) begin
                            state         <= OUT;
                            us_rdy_q      <= 1'b1;
                            wb_data_q     <= bus.ex_mem_result;
                            wb_rsd_q      <= bus.ex_mem_wb_rsd;
                            wb_we_q       <= 1'b0;
                            wb_misalign_q <= 1'b1;
                        end else if (is_load || is_store) begin
                            state        <= REQ;
                            us_rdy_q     <= 1'b0;
                            dbus_req_q   <= 1'b1;
                            dbus_we_q    <= is_store;
                            dbus_addr_q  <= {bus.ex_mem_result[31:2], 2'b00};
                            dbus_be_q    <= be_in;
                            dbus_wdata_q <= wdata_in;
                            a_q          <= eff_a;
                            funct_q      <= bus.ex_mem_funct;
                            rsd_q        <= bus.ex_mem_wb_rsd;
                        end else begin
                            state         <= OUT;
                            us_rdy_q      <= 1'b1;
                            wb_data_q     <= bus.ex_mem_result;
                            wb_rsd_q      <= bus.ex_mem_wb_rsd;
                            wb_we_q       <= (bus.ex_mem_wb_rsd != 5'h0);
                            wb_misalign_q <= 1'b0;
                        end
                    end else if (us_rdy_q && bus.us_ack) begin
                        state    <= IDLE;
                        us_rdy_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.dbus_gnt) begin
                        dbus_req_q <= 1'b0;
                        if (dbus_we_q) begin
                            state         <= OUT;
                            us_rdy_q      <= 1'b1;
                            wb_data_q     <= 32'h0;
                            wb_rsd_q      <= rsd_q;
                            wb_we_q       <= 1'b0;
                            wb_misalign_q <= 1'b0;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.dbus_rvalid) begin
                        state         <= OUT;
                        us_rdy_q      <= 1'b1;
                        wb_data_q     <= load_val;
                        wb_rsd_q      <= rsd_q;
                        wb_we_q       <= (rsd_q != 5'h0);
                        wb_misalign_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ds_ack          = ds_ack;
    assign bus.us_rdy          = us_rdy_q;
    assign bus.dbus_req        = dbus_req_q;
    assign bus.dbus_we         = dbus_we_q;
    assign bus.dbus_addr       = dbus_addr_q;
    assign bus.dbus_be         = dbus_be_q;
    assign bus.dbus_wdata      = dbus_wdata_q;
    assign bus.mem_wb_data     = wb_data_q;
    assign bus.mem_wb_rsd      = wb_rsd_q;
    assign bus.mem_wb_we       = wb_we_q;
    assign bus.mem_wb_misalign = wb_misalign_q;
endmodule

// File: tb/tb_riscv_mem.sv
// tb/tb_riscv_mem.sv - randomized self-checking bench for riscv_mem against a behavioural model
`ifndef MEM_FUNCT_W
`define MEM_FUNCT_W 4
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LH  4'd2
`define MEM_LW  4'd3
`define MEM_LBU 4'd4
`define MEM_LHU 4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module tb_riscv_mem;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;

    riscv_mem_if bus();
    riscv_mem #(.ALIGN_CHECK(1)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- behavioural reference ----
    function automatic int acc_size(input logic [3:0] f);
        if (f == `MEM_LB || f == `MEM_LBU || f == `MEM_SB) return 1;
        if (f == `MEM_LH || f == `MEM_LHU || f == `MEM_SH) return 2;
        if (f == `MEM_LW || f == `MEM_SW) return 4;
        return 0;
    endfunction

    function automatic bit is_st(input logic [3:0] f);
        return (f == `MEM_SB || f == `MEM_SH || f == `MEM_SW);
    endfunction

    function automatic bit is_misal(input logic [3:0] f, input logic [31:0] addr);
        int sz = acc_size(f);
        return (sz > 1) && ((addr % sz) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] f, input logic [31:0] addr);
        int sz = acc_size(f);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] f, input logic [31:0] d);
        case (acc_size(f))
            1: return 32'(d[7:0]) * 32'h0101_0101;
            2: return 32'(d[15:0]) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] f, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int    sz = acc_size(f);
        longint v;
        if (sz == 4) return rdata;
        v = longint'((rdata >> (8 * (addr % 4))) & ((32'h1 << (8 * sz)) - 1));
        if ((f == `MEM_LB || f == `MEM_LH) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction through the stage with us_ack high, acting as the data bus.
    task automatic run_txn(input logic [3:0] f, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rsd, input int gd, input int rd, input logic [31:0] rdata);
        bit mis = is_misal(f, addr);
        bus.ex_mem_funct = f; bus.ex_mem_result = addr; bus.ex_mem_data = data;
        bus.ex_mem_wb_rsd = rsd; bus.ds_rdy = 1'b1;
        #1;
        total++; if (bus.ds_ack !== 1'b1) begin bad++; $display("FAIL txn_ds_ack got=%b want=1", bus.ds_ack); end
        tick();
        bus.ds_rdy = 1'b0;
        if (acc_size(f) != 0 && !mis) begin
            total++;
            if (bus.dbus_req !== 1'b1 || bus.dbus_addr !== {addr[31:2], 2'b00} ||
                bus.dbus_be !== model_be(f, addr) || bus.dbus_we !== is_st(f)) begin
                bad++;
                $display("FAIL bus_req f=%0d got req=%b addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                         f, bus.dbus_req, bus.dbus_addr, bus.dbus_be, bus.dbus_we,
                         {addr[31:2], 2'b00}, model_be(f, addr), is_st(f));
            end
            if (is_st(f)) begin
                total++;
                if (bus.dbus_wdata !== model_wdata(f, data)) begin
                    bad++; $display("FAIL bus_wdata got=%h want=%h", bus.dbus_wdata, model_wdata(f, data));
                end
            end
            for (int i = 0; i < gd; i++) begin
                tick();
                total++;
                if (bus.dbus_req !== 1'b1 || bus.us_rdy !== 1'b0 || bus.dbus_addr !== {addr[31:2], 2'b00}) begin
                    bad++; $display("FAIL req_hold got req=%b us_rdy=%b addr=%h", bus.dbus_req, bus.us_rdy, bus.dbus_addr);
                end
            end
            bus.dbus_gnt = 1'b1;
            tick();
            bus.dbus_gnt = 1'b0;
            total++; if (bus.dbus_req !== 1'b0) begin bad++; $display("FAIL req_drop got=%b want=0", bus.dbus_req); end
            if (is_st(f)) begin
                total++;
                if (bus.us_rdy !== 1'b1 || bus.mem_wb_we !== 1'b0 || bus.mem_wb_data !== 32'h0 ||
                    bus.mem_wb_rsd !== rsd || bus.mem_wb_misalign !== 1'b0) begin
                    bad++;
                    $display("FAIL store_out got rdy=%b we=%b data=%h rsd=%0d mis=%b want 1 0 0 %0d 0",
                             bus.us_rdy, bus.mem_wb_we, bus.mem_wb_data, bus.mem_wb_rsd, bus.mem_wb_misalign, rsd);
                end
            end else begin
                for (int i = 0; i < rd; i++) tick();
                total++; if (bus.us_rdy !== 1'b0) begin bad++; $display("FAIL resp_wait got us_rdy=%b want=0", bus.us_rdy); end
                bus.dbus_rvalid = 1'b1; bus.dbus_rdata = rdata;
                tick();
                bus.dbus_rvalid = 1'b0;
                total++;
                if (bus.us_rdy !== 1'b1 || bus.mem_wb_data !== model_load(f, addr, rdata) ||
                    bus.mem_wb_we !== (rsd != 0) || bus.mem_wb_rsd !== rsd || bus.mem_wb_misalign !== 1'b0) begin
                    bad++;
                    $display("FAIL load_out f=%0d a=%h got rdy=%b data=%h we=%b rsd=%0d want data=%h we=%b rsd=%0d",
                             f, addr, bus.us_rdy, bus.mem_wb_data, bus.mem_wb_we, bus.mem_wb_rsd,
                             model_load(f, addr, rdata), (rsd != 0), rsd);
                end
            end
        end else begin
            total++;
            if (bus.us_rdy !== 1'b1 || bus.dbus_req !== 1'b0 || bus.mem_wb_data !== addr ||
                bus.mem_wb_rsd !== rsd || bus.mem_wb_misalign !== mis ||
                bus.mem_wb_we !== (!mis && rsd != 0)) begin
                bad++;
                $display("FAIL pass_out f=%0d got rdy=%b req=%b data=%h rsd=%0d mis=%b we=%b want data=%h mis=%b we=%b",
                         f, bus.us_rdy, bus.dbus_req, bus.mem_wb_data, bus.mem_wb_rsd, bus.mem_wb_misalign,
                         bus.mem_wb_we, addr, mis, (!mis && rsd != 0));
            end
        end
        tick();
        total++; if (bus.us_rdy !== 1'b0) begin bad++; $display("FAIL drain got us_rdy=%b want=0", bus.us_rdy); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.us_rdy !== 1'b0 || bus.dbus_req !== 1'b0 || bus.dbus_we !== 1'b0 || bus.dbus_addr !== 32'h0 ||
            bus.dbus_be !== 4'h0 || bus.dbus_wdata !== 32'h0 || bus.mem_wb_data !== 32'h0 ||
            bus.mem_wb_rsd !== 5'h0 || bus.mem_wb_we !== 1'b0 || bus.mem_wb_misalign !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b req=%b we=%b addr=%h be=%b wd=%h d=%h rsd=%0d wbwe=%b mis=%b want all 0",
                     bus.us_rdy, bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_be, bus.dbus_wdata,
                     bus.mem_wb_data, bus.mem_wb_rsd, bus.mem_wb_we, bus.mem_wb_misalign);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_nop();
        run_txn(`MEM_NOP, 32'h1234_5678, 32'h0, 5'd5, 0, 0, 32'h0);
        run_txn(`MEM_NOP, 32'h8765_4321, 32'h0, 5'd0, 0, 0, 32'h0);
        run_txn(`MEM_NOP, 32'hAAAA_0001, 32'h0, 5'd5, 0, 0, 32'h0);
    endtask

    task automatic test_lb_lbu();
        run_txn(`MEM_LB,  32'h1003, 32'h0, 5'd10, 2, 0, 32'h80AA_BBCC);
        run_txn(`MEM_LBU, 32'h1003, 32'h0, 5'd10, 2, 0, 32'h80AA_BBCC);
    endtask

    task automatic test_sh();
        run_txn(`MEM_SH, 32'h2002, 32'hDEAD_BEEF, 5'd7, 1, 0, 32'h0);
    endtask

    task automatic test_misalign();
        run_txn(`MEM_LW, 32'h3001, 32'h0, 5'd4, 0, 0, 32'h0);
        run_txn(`MEM_SH, 32'h3003, 32'h1, 5'd4, 0, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        bus.us_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ex_mem_funct = `MEM_NOP; bus.ex_mem_result = vals[i];
            bus.ex_mem_wb_rsd = 5'(i + 1); bus.ds_rdy = 1'b1;
            #1;
            total++; if (bus.ds_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack[%0d] got=%b want=1", i, bus.ds_ack); end
            tick();
            total++;
            if (bus.us_rdy !== 1'b1 || bus.mem_wb_data !== vals[i] || bus.mem_wb_rsd !== 5'(i + 1)) begin
                bad++;
                $display("FAIL b2b_out[%0d] got rdy=%b data=%h rsd=%0d want 1 %h %0d",
                         i, bus.us_rdy, bus.mem_wb_data, bus.mem_wb_rsd, vals[i], i + 1);
            end
        end
        bus.ds_rdy = 1'b0;
        tick();
        total++; if (bus.us_rdy !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", bus.us_rdy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r = 32'h5A5A_C3C3;
        bus.us_ack = 1'b0;
        bus.ex_mem_funct = `MEM_LW; bus.ex_mem_result = 32'h40; bus.ex_mem_wb_rsd = 5'd9; bus.ds_rdy = 1'b1;
        tick();
        bus.ds_rdy = 1'b0; bus.dbus_gnt = 1'b1;
        tick();
        bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b1; bus.dbus_rdata = r;
        tick();
        bus.dbus_rvalid = 1'b0;
        bus.ex_mem_funct = `MEM_NOP; bus.ex_mem_result = 32'hCAFE_F00D; bus.ex_mem_wb_rsd = 5'd3; bus.ds_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (bus.ds_ack !== 1'b0 || bus.us_rdy !== 1'b1 || bus.mem_wb_data !== r ||
                bus.mem_wb_rsd !== 5'd9 || bus.mem_wb_we !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d] got ack=%b rdy=%b data=%h rsd=%0d we=%b want 0 1 %h 9 1",
                         i, bus.ds_ack, bus.us_rdy, bus.mem_wb_data, bus.mem_wb_rsd, bus.mem_wb_we, r);
            end
            tick();
        end
        bus.us_ack = 1'b1;
        #1;
        total++; if (bus.ds_ack !== 1'b1) begin bad++; $display("FAIL bp_release_ack got=%b want=1", bus.ds_ack); end
        tick();
        bus.ds_rdy = 1'b0;
        total++;
        if (bus.us_rdy !== 1'b1 || bus.mem_wb_data !== 32'hCAFE_F00D || bus.mem_wb_rsd !== 5'd3) begin
            bad++;
            $display("FAIL bp_overlap got rdy=%b data=%h rsd=%0d want 1 cafef00d 3",
                     bus.us_rdy, bus.mem_wb_data, bus.mem_wb_rsd);
        end
        tick();
        total++; if (bus.us_rdy !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", bus.us_rdy); end
    endtask

    task automatic test_stray();
        bus.dbus_gnt = 1'b1; bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            tick();
            total++;
            if (bus.us_rdy !== 1'b0 || bus.dbus_req !== 1'b0) begin
                bad++; $display("FAIL stray got rdy=%b req=%b want 0 0", bus.us_rdy, bus.dbus_req);
            end
        end
        bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        run_txn(`MEM_NOP, 32'h0000_0077, 32'h0, 5'd5, 0, 0, 32'h0);
        bus.ex_mem_funct = `MEM_SW; bus.ex_mem_result = 32'h100; bus.ex_mem_data = 32'h1;
        bus.ex_mem_wb_rsd = 5'd6; bus.ds_rdy = 1'b1;
        tick();
        bus.ds_rdy = 1'b0;
        total++; if (bus.dbus_req !== 1'b1) begin bad++; $display("FAIL rst_mid_req_before got=%b want=1", bus.dbus_req); end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (bus.dbus_req !== 1'b0 || bus.us_rdy !== 1'b0 || bus.mem_wb_we !== 1'b0) begin
            bad++; $display("FAIL rst_mid_async got req=%b rdy=%b we=%b want 0 0 0", bus.dbus_req, bus.us_rdy, bus.mem_wb_we);
        end
        tick();
        rstn = 1'b1;
        bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'h1234_0000;
        repeat (3) begin
            tick();
            total++;
            if (bus.us_rdy !== 1'b0 || bus.dbus_req !== 1'b0) begin
                bad++; $display("FAIL rst_mid_stray got rdy=%b req=%b want 0 0", bus.us_rdy, bus.dbus_req);
            end
        end
        bus.dbus_rvalid = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [3:0]  f    = 4'($urandom_range(0, 11));
            logic [31:0] addr = $urandom;
            logic [31:0] data = $urandom;
            logic [4:0]  rsd  = 5'($urandom_range(0, 31));
            logic [31:0] rdat = $urandom;
            run_txn(f, addr, data, rsd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rdat);
        end
    endtask

    initial begin
        bus.ds_rdy = 1'b0; bus.ex_mem_result = 32'h0; bus.ex_mem_funct = `MEM_NOP;
        bus.ex_mem_data = 32'h0; bus.ex_mem_wb_rsd = 5'h0; bus.dbus_gnt = 1'b0;
        bus.dbus_rvalid = 1'b0; bus.dbus_rdata = 32'h0; bus.us_ack = 1'b1;
        test_reset();
        test_nop();
        test_lb_lbu();
        test_sh();
        test_misalign();
        test_back_to_back();
        test_backpressure();
        test_stray();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
